// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator: mode encoding, box
// geometry, colour-bar table and the helpers used by the top and box_mover.
package pattern_pkg;

    // Rendering modes. Raw select codes above GREY fold back to GRADIENT.
    typedef enum logic [2:0] {
        GRADIENT = 3'd0,
        BARS     = 3'd1,
        CHECKER  = 3'd2,
        BOX      = 3'd3,
        GREY     = 3'd4
    } mode_e;

    // Edge length of the moving box, in pixels.
    localparam int BOX_SIZE = 32;

    // Colour bars, left to right. Each entry is {r_on, g_on, b_on}.
    localparam int NUM_BARS = 8;
    localparam logic [NUM_BARS-1:0][2:0] BAR_RGB = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

    // One axis of box motion: position plus direction (1 = increasing).
    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // Map a raw 3-bit select onto a legal mode.
    function automatic mode_e decode_mode(input logic [2:0] sel);
        mode_e m;
        case (sel)
            3'd1:    m = BARS;
            3'd2:    m = CHECKER;
            3'd3:    m = BOX;
            3'd4:    m = GREY;
            default: m = GRADIENT;
        endcase
        return m;
    endfunction

    // Advance one axis by step. The sum/difference is formed in 11 bits so
    // that running past the upper limit or below zero is visible before the
    // result is cut back to 10 bits. Crossing a limit clamps to it and flips
    // the direction in the same update; landing exactly on a limit does not.
    function automatic axis_t axis_step(input axis_t       cur,
                                        input logic [10:0] lim,
                                        input logic [10:0] step);
        axis_t       res;
        logic [10:0] nxt;
        res = cur;
        if (cur.dir) begin
            nxt = {1'b0, cur.pos} + step;
            if (nxt > lim) begin
                res.pos = lim[9:0];
                res.dir = 1'b0;
            end else begin
                res.pos = nxt[9:0];
            end
        end else begin
            nxt = {1'b0, cur.pos} - step;
            if (nxt[10]) begin
                res.pos = 10'd0;
                res.dir = 1'b1;
            end else begin
                res.pos = nxt[9:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/box_mover.sv
// Bouncing-box position. Moves by BOX_STEP on each step_en pulse and
// reverses at the screen edges; holds still otherwise.
module box_mover
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_STEP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    localparam logic [10:0] X_LIM = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP  = 11'(BOX_STEP);

    axis_t x_q, x_d;
    axis_t y_q, y_d;

    // Next position: both axes step together, only when enabled.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (step_en) begin
            x_d = axis_step(x_q, X_LIM, STEP);
            y_d = axis_step(y_q, Y_LIM, STEP);
        end
    end

    // Position/direction registers; reset parks the box at the origin heading +x/+y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '{pos: 10'd0, dir: 1'b1};
            y_q <= '{pos: 10'd0, dir: 1'b1};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign box_x = x_q.pos;
    assign box_y = y_q.pos;

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator. Colours each incoming pixel coordinate
// according to the active mode and delivers it two cycles later.
//
// Stream handshake: video_on is the per-beat valid for the incoming pixel and
// video_on_out is the matching valid on the outgoing colour. There is no
// ready: one pixel is accepted every cycle and the pipeline never stalls.
//
// The colour is computed from the live inputs against the mode/box state in
// force when the pixel is sampled, so the end-of-frame pixel is still drawn
// with the old frame's settings even though those change on that same edge.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLOR_W  = 4,
    parameter int BOX_STEP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               video_on,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [2:0]         mode_sel,
    input  logic               mode_req,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               video_on_out,
    output logic               frame_tick,
    output logic [2:0]         mode_active,
    output logic [7:0]         frame_cnt
);

    localparam int                 BAR_W    = H_ACTIVE / NUM_BARS;
    localparam logic [COLOR_W-1:0] ONES     = '1;
    localparam logic [COLOR_W-1:0] GRAD_B   = COLOR_W'(4);
    localparam logic [COLOR_W-1:0] FILL_G   = COLOR_W'(1);
    localparam logic [COLOR_W-1:0] FILL_B   = COLOR_W'(3);
    localparam logic [COLOR_W-1:0] GREY_LVL = COLOR_W'(1) << (COLOR_W - 1);

    // Mode control and frame bookkeeping.
    mode_e      pending_q, pending_d;
    mode_e      mode_q, mode_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_tick_q;

    // Two-stage colour pipeline.
    logic               s1_vld_q, s2_vld_q;
    logic [COLOR_W-1:0] s1_r_q, s1_g_q, s1_b_q;
    logic [COLOR_W-1:0] s1_r_d, s1_g_d, s1_b_d;
    logic [COLOR_W-1:0] s2_r_q, s2_g_q, s2_b_q;

    // Pattern helpers.
    logic       eof;
    logic       in_grad;
    logic       in_box;
    logic       checker_on;
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;
    logic [9:0] box_x, box_y;

    assign eof = video_on
              && (pix_x == 10'(H_ACTIVE - 1))
              && (pix_y == 10'(V_ACTIVE - 1));

    assign in_grad    = (pix_x < 10'd256) && (pix_y < 10'd256);
    assign checker_on = pix_x[5] ^ pix_y[5];
    assign in_box     = ({1'b0, pix_x} >= {1'b0, box_x})
                     && ({1'b0, pix_x} <  {1'b0, box_x} + 11'(BOX_SIZE))
                     && ({1'b0, pix_y} >= {1'b0, box_y})
                     && ({1'b0, pix_y} <  {1'b0, box_y} + 11'(BOX_SIZE));

    // Bar index by comparing against each bar's left edge; no divider needed.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < NUM_BARS; i++) begin
            if (pix_x >= 10'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign bar_rgb = BAR_RGB[bar_idx];

    // The box only moves on frame boundaries of frames drawn in box mode.
    box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_STEP (BOX_STEP)
    ) u_box_mover (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (eof && (mode_q == BOX)),
        .box_x   (box_x),
        .box_y   (box_y)
    );

    // Mode handoff: requests land in pending (last one wins); active mode only
    // changes at the frame boundary, and a request on that very sample counts.
    always_comb begin
        pending_d   = pending_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        if (mode_req) begin
            pending_d = decode_mode(mode_sel);
        end
        if (eof) begin
            mode_d      = pending_d;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Control registers: pending/active mode, frame counter and the end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= GRADIENT;
            mode_q       <= GRADIENT;
            frame_cnt_q  <= 8'd0;
            frame_tick_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            mode_q       <= mode_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= eof;
        end
    end

    // Per-pixel colour for the current mode; blanked pixels are always black.
    always_comb begin
        s1_r_d = '0;
        s1_g_d = '0;
        s1_b_d = '0;
        if (video_on) begin
            case (mode_q)
                GRADIENT: begin
                    if (in_grad) begin
                        s1_r_d = pix_x[7:8-COLOR_W];
                        s1_g_d = pix_y[7:8-COLOR_W];
                        s1_b_d = GRAD_B;
                    end else begin
                        s1_g_d = FILL_G;
                        s1_b_d = FILL_B;
                    end
                end
                BARS: begin
                    s1_r_d = bar_rgb[2] ? ONES : '0;
                    s1_g_d = bar_rgb[1] ? ONES : '0;
                    s1_b_d = bar_rgb[0] ? ONES : '0;
                end
                CHECKER: begin
                    if (checker_on) begin
                        s1_r_d = ONES;
                        s1_g_d = ONES;
                        s1_b_d = ONES;
                    end
                end
                BOX: begin
                    s1_b_d = ONES;
                    if (in_box) begin
                        s1_r_d = ONES;
                        s1_g_d = ONES;
                    end
                end
                GREY: begin
                    s1_r_d = GREY_LVL;
                    s1_g_d = GREY_LVL;
                    s1_b_d = GREY_LVL;
                end
                default: begin
                    s1_r_d = '0;
                    s1_g_d = '0;
                    s1_b_d = '0;
                end
            endcase
        end
    end

    // Pipeline registers: stage 1 holds the computed colour, stage 2 drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_r_q   <= '0;
            s1_g_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_r_q   <= '0;
            s2_g_q   <= '0;
            s2_b_q   <= '0;
        end else begin
            s1_vld_q <= video_on;
            s1_r_q   <= s1_r_d;
            s1_g_q   <= s1_g_d;
            s1_b_q   <= s1_b_d;
            s2_vld_q <= s1_vld_q;
            s2_r_q   <= s1_r_q;
            s2_g_q   <= s1_g_q;
            s2_b_q   <= s1_b_q;
        end
    end

    assign r            = s2_r_q;
    assign g            = s2_g_q;
    assign b            = s2_b_q;
    assign video_on_out = s2_vld_q;
    assign frame_tick   = frame_tick_q;
    assign mode_active  = mode_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
